math_round_ctrl: RTL and testbench

Round sequencer for the CPLD mental-arithmetic game. It paces one game round:
- draws NUM_TERMS operands from the free-running 5-bit LFSR and shows each for a fixed dwell;
- blanks the display, then waits for the player's switch answer;
- judges the answer against the internally accumulated sum and keeps a saturating score shown as a thermometer on the LED bar.

It sits between the LFSR/slow-tick sources and the BCD display path, replacing the fixed slot-count sequencing with a handshake-driven FSM.

---
 rtl/math_game_pkg.sv | 22 ++
 rtl/dwell_timer.sv | 29 ++
 rtl/math_round_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_math_round_ctrl.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/math_game_pkg.sv
// Shared definitions for the mental-arithmetic game: round FSM states and phase
// encoding, score limits and default pacing constants used by the sequencer and display top.
package math_game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SHOW   = 3'd1,
        ST_GAP    = 3'd2,
        ST_ANSWER = 3'd3,
        ST_JUDGE  = 3'd4,
        ST_RESULT = 3'd5
    } round_state_t;

    localparam int                PHASE_W                = 3;
    localparam int                SCORE_W                = 3;
    localparam logic [SCORE_W-1:0] SCORE_MAX             = 3'd7;
    localparam int                DEFAULT_DWELL          = 10;
    localparam int                DEFAULT_NUM_TERMS      = 5;
    localparam int                DEFAULT_OP_W           = 5;
    localparam int                DEFAULT_ANSWER_TIMEOUT = 1000;

endpackage

// File: rtl/dwell_timer.sv
// Up-counter pacing the SHOW, GAP and RESULT windows; done is high on the
// last cycle of a DWELL-cycle window while enabled.
module dwell_timer #(
    parameter int DWELL = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic done
);

    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (en) begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

    assign done = en && (count_reg == CNT_W'(DWELL - 1));

endmodule

// File: rtl/math_round_ctrl.sv
// Round sequencer: shows NUM_TERMS LFSR operands, waits for the player's answer,
// judges it against the running sum and keeps a saturating score. Optional
// answer timeout is enabled by defining ROUND_TIMEOUT_EN.
module math_round_ctrl
    import math_game_pkg::*;
#(
    parameter int NUM_TERMS      = DEFAULT_NUM_TERMS,
    parameter int OP_W           = DEFAULT_OP_W,
    parameter int DWELL          = DEFAULT_DWELL,
    parameter int ANSWER_TIMEOUT = DEFAULT_ANSWER_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [OP_W-1:0]    rand_num,
    input  logic [7:0]         answer,
    input  logic               submit,
    output logic [7:0]         disp_value,
    output logic [PHASE_W-1:0] phase,
    output logic               busy,
    output logic               result_valid,
    output logic               result_correct,
    output logic               timed_out,
    output logic [6:0]         score_bar
);

    if (NUM_TERMS < 1 || NUM_TERMS > 8) begin : g_chk_terms
        $error("math_round_ctrl: NUM_TERMS must be 1..8");
    end
    if (NUM_TERMS * ((1 << OP_W) - 1) > 255) begin : g_chk_sum
        $error("math_round_ctrl: NUM_TERMS*(2^OP_W-1) exceeds 8-bit sum");
    end
    if (DWELL < 1) begin : g_chk_dwell
        $error("math_round_ctrl: DWELL must be at least 1");
    end

    round_state_t       state_reg, state_next;
    logic [2:0]         term_idx_reg;
    logic [OP_W-1:0]    operand_reg;
    logic [7:0]         sum_reg;
    logic [7:0]         answer_lag_reg;
    logic [7:0]         answer_latch_reg;
    logic [SCORE_W-1:0] score_reg;
    logic               correct_reg;

    logic timer_clr, timer_en, timer_done;
    logic last_term, answer_expired, timeout_hit, judge_correct;

    dwell_timer #(.DWELL(DWELL)) u_dwell (
        .clk  (clk),
        .rst  (rst),
        .clr  (timer_clr),
        .en   (timer_en),
        .done (timer_done)
    );

    assign last_term     = (term_idx_reg == 3'(NUM_TERMS - 1));
    assign judge_correct = !timeout_hit && (answer_latch_reg == sum_reg);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        timer_clr  = 1'b1;
        timer_en   = 1'b0;
        disp_value = 8'd0;
        case (state_reg)
            ST_IDLE: begin
                if (start) state_next = ST_SHOW;
            end
            ST_SHOW: begin
                timer_en   = 1'b1;
                timer_clr  = timer_done;
                disp_value = 8'(operand_reg);
                if (timer_done && last_term) state_next = ST_GAP;
            end
            ST_GAP: begin
                timer_en  = 1'b1;
                timer_clr = timer_done;
                if (timer_done) state_next = ST_ANSWER;
            end
            ST_ANSWER: begin
                disp_value = answer_lag_reg;
                if (submit || answer_expired) state_next = ST_JUDGE;
            end
            ST_JUDGE: begin
                state_next = ST_RESULT;
            end
            ST_RESULT: begin
                timer_en   = 1'b1;
                timer_clr  = timer_done;
                disp_value = sum_reg;
                if (timer_done) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Operand capture, running sum, answer latch and score bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            term_idx_reg     <= '0;
            operand_reg      <= '0;
            sum_reg          <= '0;
            answer_lag_reg   <= '0;
            answer_latch_reg <= '0;
            score_reg        <= '0;
            correct_reg      <= 1'b0;
        end else begin
            answer_lag_reg <= answer;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        term_idx_reg <= '0;
                        operand_reg  <= rand_num;
                        sum_reg      <= 8'(rand_num);
                    end
                end
                ST_SHOW: begin
                    if (timer_done && !last_term) begin
                        term_idx_reg <= term_idx_reg + 3'd1;
                        operand_reg  <= rand_num;
                        sum_reg      <= sum_reg + 8'(rand_num);
                    end
                end
                ST_ANSWER: begin
                    if (submit) answer_latch_reg <= answer;
                end
                ST_JUDGE: begin
                    correct_reg <= judge_correct;
                    if (judge_correct) begin
                        if (score_reg != SCORE_MAX) score_reg <= score_reg + SCORE_W'(1);
                    end else begin
                        if (score_reg != '0) score_reg <= score_reg - SCORE_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ROUND_TIMEOUT_EN
    localparam int TO_W = (ANSWER_TIMEOUT > 1) ? $clog2(ANSWER_TIMEOUT) : 1;

    logic [TO_W-1:0] to_cnt_reg;
    logic            timeout_hit_reg;
    logic            timed_out_reg;

    assign answer_expired = (state_reg == ST_ANSWER) && (to_cnt_reg == TO_W'(ANSWER_TIMEOUT - 1));
    assign timeout_hit    = timeout_hit_reg;
    assign timed_out      = result_valid && timed_out_reg;

    // A submit in the final allowed cycle beats the timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt_reg      <= '0;
            timeout_hit_reg <= 1'b0;
            timed_out_reg   <= 1'b0;
        end else begin
            if (state_reg == ST_ANSWER) begin
                to_cnt_reg      <= to_cnt_reg + TO_W'(1);
                timeout_hit_reg <= answer_expired && !submit;
            end else begin
                to_cnt_reg <= '0;
            end
            if (state_reg == ST_JUDGE) timed_out_reg <= timeout_hit_reg;
        end
    end
`else
    assign answer_expired = 1'b0;
    assign timeout_hit    = 1'b0;
    assign timed_out      = 1'b0;
`endif

    assign phase          = state_reg;
    assign busy           = (state_reg != ST_IDLE);
    assign result_valid   = (state_reg == ST_RESULT);
    assign result_correct = result_valid && correct_reg;

    for (genvar gi = 0; gi < 7; gi++) begin : g_bar
        assign score_bar[gi] = (score_reg > SCORE_W'(gi));
    end

endmodule

// File: tb/tb_math_round_ctrl.sv
// Self-checking bench for math_round_ctrl: randomized rounds checked against a
// cycle-timeline model of the round built from the documented pacing rules.
module tb_math_round_ctrl;

    localparam int D  = 4;
    localparam int NT = 5;
    localparam int AT = 16;

    typedef int ops_t [NT];

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       submit = 1'b0;
    logic [4:0] rand_num = '0;
    logic [7:0] answer = '0;
    logic [7:0] disp_value;
    logic [2:0] phase;
    logic       busy, result_valid, result_correct, timed_out;
    logic [6:0] score_bar;

    int tests_run = 0;
    int tests_failed = 0;
    int model_score = 0;
    bit expired;
    int obs_disp[$], obs_phase[$], obs_busy[$], obs_rv[$], obs_rc[$], obs_to[$], obs_bar[$];
    int drv_ans[$];

    always #5 clk = ~clk;

    math_round_ctrl #(
        .NUM_TERMS      (NT),
        .OP_W           (5),
        .DWELL          (D),
        .ANSWER_TIMEOUT (AT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .rand_num       (rand_num),
        .answer         (answer),
        .submit         (submit),
        .disp_value     (disp_value),
        .phase          (phase),
        .busy           (busy),
        .result_valid   (result_valid),
        .result_correct (result_correct),
        .timed_out      (timed_out),
        .score_bar      (score_bar)
    );

    // ---------------- reference model ----------------
    function automatic int model_phase(int e, int w);
        if (e <= NT * D) return 1;
        if (e <= (NT + 1) * D) return 2;
        if (e <= (NT + 1) * D + w) return 3;
        if (e == (NT + 1) * D + w + 1) return 4;
        if (e <= (NT + 2) * D + w + 1) return 5;
        return 0;
    endfunction

    function automatic int model_sum(ops_t ops);
        int s = 0;
        foreach (ops[k]) s += ops[k];
        return s;
    endfunction

    // Expected display after edge e of a round; -1 where the value is unconstrained.
    function automatic int model_disp(int e, ops_t ops, int w);
        case (model_phase(e, w))
            1: return ops[(e - 1) / D];
            3: return drv_ans[e - 1];
            4: return -1;
            5: return model_sum(ops);
            default: return 0;
        endcase
    endfunction

    function automatic int bar_of(int s);
        return (1 << s) - 1;
    endfunction

    function automatic int next_score(int s, bit ok);
        if (ok) return (s < 7) ? s + 1 : 7;
        return (s > 0) ? s - 1 : 0;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
        obs_disp.push_back(int'(disp_value));
        obs_phase.push_back(int'(phase));
        obs_busy.push_back(int'(busy));
        obs_rv.push_back(int'(result_valid));
        obs_rc.push_back(int'(result_correct));
        obs_to.push_back(int'(timed_out));
        obs_bar.push_back(int'(score_bar));
    endtask

    // Plays one round from IDLE back to IDLE, recording outputs after every edge.
    task automatic run_round(input ops_t ops, input int ans, input int w,
                             input bit do_submit, input bit noise);
        int e, ans_cnt;
        obs_disp.delete(); obs_phase.delete(); obs_busy.delete(); obs_rv.delete();
        obs_rc.delete(); obs_to.delete(); obs_bar.delete(); drv_ans.delete();
        expired = 1'b0;
        start    = 1'b1;
        submit   = 1'b0;
        rand_num = 5'(ops[0]);
        answer   = 8'($urandom_range(0, 255));
        drv_ans.push_back(int'(answer));
        step();
        start   = 1'b0;
        e       = 1;
        ans_cnt = 0;
        while (obs_phase[obs_phase.size() - 1] != 0) begin
            if (e >= 400) begin
                expired = 1'b1;
                break;
            end
            rand_num = 5'($urandom_range(0, 31));
            if (e % D == 0 && e / D < NT) rand_num = 5'(ops[e / D]);
            answer = 8'($urandom_range(0, 255));
            start  = 1'b0;
            submit = 1'b0;
            if (noise && e <= (NT + 1) * D) begin
                start  = 1'($urandom_range(0, 1));
                submit = 1'($urandom_range(0, 1));
            end
            if (obs_phase[obs_phase.size() - 1] == 3) begin
                ans_cnt++;
                if (do_submit && ans_cnt == w) begin
                    submit = 1'b1;
                    answer = 8'(ans);
                    if (noise) start = 1'b1;
                end
            end
            drv_ans.push_back(int'(answer));
            step();
            e++;
        end
        start  = 1'b0;
        submit = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if ({disp_value, phase, busy, result_valid, result_correct, timed_out, score_bar} !== '0) begin
            tests_failed++;
            $display("FAIL reset_hold: disp=%0d phase=%0d busy=%0b rv=%0b rc=%0b to=%0b bar=%b, expected all 0",
                     disp_value, phase, busy, result_valid, result_correct, timed_out, score_bar);
        end
        rst = 1'b0;
        step();
        tests_run++;
        if ({disp_value, phase, busy, result_valid, result_correct, timed_out, score_bar} !== '0) begin
            tests_failed++;
            $display("FAIL reset_idle: disp=%0d phase=%0d busy=%0b bar=%b, expected all 0",
                     disp_value, phase, busy, score_bar);
        end
    endtask

    task automatic test_operand_sequence();
        ops_t ops = '{3, 7, 1, 30, 2};
        int w = 2;
        int len, jr, bar_old, bar_new;
        bit ok;
        bar_old = bar_of(model_score);
        run_round(ops, 43, w, 1'b1, 1'b0);
        ok = (model_sum(ops) == 43);
        model_score = next_score(model_score, ok);
        bar_new = bar_of(model_score);
        len = (NT + 2) * D + w + 2;
        jr  = (NT + 1) * D + w + 1;
        tests_run++;
        if (expired || obs_phase.size() != len) begin
            tests_failed++;
            $display("FAIL seq_round_len: got %0d cycles, expected %0d", obs_phase.size(), len);
        end else begin
            for (int i = 0; i < len; i++) begin
                int e, ph, dv, bx;
                e  = i + 1;
                ph = model_phase(e, w);
                dv = model_disp(e, ops, w);
                bx = (e > (NT + 1) * D + w + 1) ? bar_new : bar_old;
                tests_run++;
                if (obs_phase[i] != ph || obs_busy[i] != int'(ph != 0) || obs_rv[i] != int'(ph == 5) ||
                    (dv >= 0 && obs_disp[i] != dv) || obs_bar[i] != bx ||
                    (ph == 5 && (obs_rc[i] != int'(ok) || obs_to[i] != 0))) begin
                    tests_failed++;
                    $display("FAIL seq_trace cycle %0d: phase %0d disp %0d bar %0d rc %0d, expected phase %0d disp %0d bar %0d rc %0d",
                             i, obs_phase[i], obs_disp[i], obs_bar[i], obs_rc[i], ph, dv, bx, ok);
                end
            end
            tests_run++;
            if (obs_disp[jr] != 43 || obs_rc[jr] != 1 || obs_bar[jr] != 7'b0000001) begin
                tests_failed++;
                $display("FAIL seq_result: disp %0d rc %0d bar %0d, expected 43 1 1",
                         obs_disp[jr], obs_rc[jr], obs_bar[jr]);
            end
        end
    endtask

    task automatic test_wrong_answer();
        ops_t ops = '{3, 7, 1, 30, 2};
        int jr;
        for (int r = 0; r < 2; r++) begin
            run_round(ops, 42, 3, 1'b1, 1'b0);
            model_score = next_score(model_score, 1'b0);
            jr = (NT + 1) * D + 3 + 1;
            tests_run++;
            if (expired || obs_phase.size() != (NT + 2) * D + 3 + 2 || obs_rc[jr] != 0 ||
                obs_rv[jr] != 1 || obs_bar[jr] != bar_of(model_score) || obs_disp[jr] != 43) begin
                tests_failed++;
                $display("FAIL wrong_round%0d: len %0d rc %0d bar %0d disp %0d, expected len %0d rc 0 bar %0d disp 43",
                         r, obs_phase.size(), expired ? -1 : obs_rc[jr], expired ? -1 : obs_bar[jr],
                         expired ? -1 : obs_disp[jr], (NT + 2) * D + 5, bar_of(model_score));
            end
        end
    endtask

    task automatic test_ignored_inputs();
        ops_t ops;
        int w = 1, jr, sum, bad;
        foreach (ops[k]) ops[k] = $urandom_range(0, 31);
        sum = model_sum(ops);
        run_round(ops, sum, w, 1'b1, 1'b1);
        model_score = next_score(model_score, 1'b1);
        jr = (NT + 1) * D + w + 1;
        tests_run++;
        if (expired || obs_phase.size() != (NT + 2) * D + w + 2) begin
            tests_failed++;
            $display("FAIL ignore_round_len: got %0d cycles, expected %0d", obs_phase.size(), (NT + 2) * D + w + 2);
        end else begin
            bad = 0;
            for (int i = 0; i < (NT + 1) * D; i++)
                if (obs_disp[i] != model_disp(i + 1, ops, w) || obs_phase[i] != model_phase(i + 1, w)) bad++;
            tests_run++;
            if (bad != 0) begin
                tests_failed++;
                $display("FAIL ignore_show_gap: %0d cycles differ from the expected operand/blank timeline, expected 0", bad);
            end
            tests_run++;
            if (obs_rc[jr] != 1 || obs_disp[jr] != sum || obs_bar[jr] != bar_of(model_score)) begin
                tests_failed++;
                $display("FAIL ignore_result: rc %0d disp %0d bar %0d, expected 1 %0d %0d",
                         obs_rc[jr], obs_disp[jr], obs_bar[jr], sum, bar_of(model_score));
            end
        end
    endtask

    task automatic test_saturation();
        ops_t ops;
        int jr;
        for (int r = 0; r < 8; r++) begin
            foreach (ops[k]) ops[k] = $urandom_range(0, 31);
            run_round(ops, model_sum(ops), 1, 1'b1, 1'b0);
            model_score = next_score(model_score, 1'b1);
            jr = (NT + 1) * D + 2;
            tests_run++;
            if (expired || obs_phase.size() != (NT + 2) * D + 3 || obs_bar[jr] != bar_of(model_score) ||
                obs_rc[jr] != 1) begin
                tests_failed++;
                $display("FAIL saturate_round%0d: bar %0d rc %0d, expected bar %0d rc 1",
                         r, expired ? -1 : obs_bar[jr], expired ? -1 : obs_rc[jr], bar_of(model_score));
            end
        end
        tests_run++;
        if (score_bar !== 7'b1111111) begin
            tests_failed++;
            $display("FAIL saturate_final: bar %b, expected 1111111", score_bar);
        end
    endtask

    task automatic test_mid_round_reset();
        ops_t ops;
        int jr;
        start    = 1'b1;
        rand_num = 5'd9;
        step();
        start = 1'b0;
        repeat (2 * D) step();
        tests_run++;
        if (phase !== 3'd1 || disp_value === 8'd0) begin
            tests_failed++;
            $display("FAIL midrst_pre: phase %0d disp %0d, expected SHOW (1) with operand shown", phase, disp_value);
        end
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        tests_run++;
        if ({disp_value, phase, busy, result_valid, result_correct, timed_out, score_bar} !== '0) begin
            tests_failed++;
            $display("FAIL midrst_abort: disp=%0d phase=%0d busy=%0b bar=%b, expected all 0",
                     disp_value, phase, busy, score_bar);
        end
        rst = 1'b0;
        model_score = 0;
        step();
        foreach (ops[k]) ops[k] = $urandom_range(0, 31);
        run_round(ops, model_sum(ops), 2, 1'b1, 1'b0);
        model_score = next_score(model_score, 1'b1);
        jr = (NT + 1) * D + 3;
        tests_run++;
        if (expired || obs_phase.size() != (NT + 2) * D + 4 || obs_bar[jr] != 7'b0000001 ||
            obs_disp[jr] != model_sum(ops)) begin
            tests_failed++;
            $display("FAIL midrst_newround: len %0d bar %0d disp %0d, expected len %0d bar 1 disp %0d",
                     obs_phase.size(), expired ? -1 : obs_bar[jr], expired ? -1 : obs_disp[jr],
                     (NT + 2) * D + 4, model_sum(ops));
        end
    endtask

    task automatic test_random_rounds();
        ops_t ops;
        int w, ans, sum, len, bar_old, bar_new;
        bit ok;
        for (int r = 0; r < 6; r++) begin
            foreach (ops[k]) ops[k] = $urandom_range(0, 31);
            sum = model_sum(ops);
            ok  = 1'($urandom_range(0, 1));
            ans = ok ? sum : (sum + 1 + $urandom_range(0, 20)) % 256;
            w   = $urandom_range(1, 5);
            bar_old = bar_of(model_score);
            run_round(ops, ans, w, 1'b1, 1'b0);
            model_score = next_score(model_score, ok);
            bar_new = bar_of(model_score);
            len = (NT + 2) * D + w + 2;
            tests_run++;
            if (expired || obs_phase.size() != len) begin
                tests_failed++;
                $display("FAIL rand_round%0d_len: got %0d cycles, expected %0d", r, obs_phase.size(), len);
            end else begin
                for (int i = 0; i < len; i++) begin
                    int e, ph, dv, bx;
                    e  = i + 1;
                    ph = model_phase(e, w);
                    dv = model_disp(e, ops, w);
                    bx = (e > (NT + 1) * D + w + 1) ? bar_new : bar_old;
                    tests_run++;
                    if (obs_phase[i] != ph || obs_busy[i] != int'(ph != 0) || obs_rv[i] != int'(ph == 5) ||
                        (dv >= 0 && obs_disp[i] != dv) || obs_bar[i] != bx ||
                        (ph == 5 && (obs_rc[i] != int'(ok) || obs_to[i] != 0))) begin
                        tests_failed++;
                        $display("FAIL rand_round%0d_trace cycle %0d: phase %0d disp %0d bar %0d rc %0d, expected phase %0d disp %0d bar %0d rc %0d",
                                 r, i, obs_phase[i], obs_disp[i], obs_bar[i], obs_rc[i], ph, dv, bx, ok);
                    end
                end
            end
        end
    endtask

`ifdef ROUND_TIMEOUT_EN
    task automatic test_timeout();
        ops_t ops;
        int sum, jr, n_ans;
        foreach (ops[k]) ops[k] = $urandom_range(0, 31);
        sum = model_sum(ops);
        jr  = (NT + 1) * D + AT + 1;
        run_round(ops, sum, 0, 1'b0, 1'b0);
        model_score = next_score(model_score, 1'b0);
        n_ans = 0;
        foreach (obs_phase[i]) if (obs_phase[i] == 3) n_ans++;
        tests_run++;
        if (expired || obs_phase.size() != (NT + 2) * D + AT + 2 || n_ans != AT) begin
            tests_failed++;
            $display("FAIL timeout_len: len %0d answer cycles %0d, expected len %0d answer cycles %0d",
                     obs_phase.size(), n_ans, (NT + 2) * D + AT + 2, AT);
        end else begin
            tests_run++;
            if (obs_to[jr] != 1 || obs_rc[jr] != 0 || obs_bar[jr] != bar_of(model_score)) begin
                tests_failed++;
                $display("FAIL timeout_result: to %0d rc %0d bar %0d, expected 1 0 %0d",
                         obs_to[jr], obs_rc[jr], obs_bar[jr], bar_of(model_score));
            end
        end
        run_round(ops, sum, AT, 1'b1, 1'b0);
        model_score = next_score(model_score, 1'b1);
        tests_run++;
        if (expired || obs_phase.size() != (NT + 2) * D + AT + 2 || obs_to[jr] != 0 || obs_rc[jr] != 1 ||
            obs_bar[jr] != bar_of(model_score)) begin
            tests_failed++;
            $display("FAIL timeout_last_submit: len %0d to %0d rc %0d, expected len %0d to 0 rc 1",
                     obs_phase.size(), expired ? -1 : obs_to[jr], expired ? -1 : obs_rc[jr],
                     (NT + 2) * D + AT + 2);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_operand_sequence();
        test_wrong_answer();
        test_ignored_inputs();
        test_saturation();
        test_mid_round_reset();
        test_random_rounds();
`ifdef ROUND_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached before the summary");
        $fatal(1, "watchdog");
    end

endmodule
